// File: rtl/ack_bus_client.sv
// Requester end of the shared ACK bus: counts host completions, raises req until
// the arbiter grants this source, retires one ACK per grant, then releases for one cycle.
module ack_bus_client #(
  parameter logic [1:0] SRC_ID  = 2'b00,
  parameter int         CNT_W   = 3,
  parameter int         TO_W    = 8,
  parameter int         TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done_pulse,
  output logic             req,
  input  logic             ack_ready,
  input  logic [1:0]       winner_source_id,
  input  logic             ack_event,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             busy,
  output logic             overflow,
  output logic             timeout_err,
  output logic             proto_err,
  input  logic             clr_err
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0]  TO_MAX  = '1;
  localparam logic [TO_W-1:0]  TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic             overflow_q, overflow_d;
  logic             timeout_q, timeout_d;
  logic             proto_q, proto_d;

  logic accept, proto_hit, ovf_hit, timeout_hit;

  always_comb begin
    accept      = (state_q == REQ) && ack_ready && ack_event && (winner_source_id == SRC_ID);
    proto_hit   = (state_q == REQ) && ack_ready &&
                  ((winner_source_id != SRC_ID) || !ack_event);
    timeout_hit = (state_q == REQ) && !accept && (timer_q == TO_LAST);

    cnt_d   = cnt_q;
    ovf_hit = 1'b0;
    if (done_pulse && !accept) begin
      if (cnt_q == CNT_MAX) ovf_hit = 1'b1;
      else                  cnt_d   = cnt_q + CNT_ONE;
    end else if (!done_pulse && accept) begin
      cnt_d = cnt_q - CNT_ONE;
    end

    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if ((cnt_q != '0) || done_pulse) state_d = REQ;
      end
      REQ: begin
        if (accept) begin
          state_d = GAP;
          timer_d = '0;
        end else if (timer_q != TO_MAX) begin
          timer_d = timer_q + TO_ONE;
        end
      end
      GAP: begin
        // Decide on the post-update count so a completion arriving in GAP is not lost.
        timer_d = '0;
        state_d = (cnt_d != '0) ? REQ : IDLE;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // A set condition in the same cycle overrides clr_err.
    overflow_d = ovf_hit     | (overflow_q & ~clr_err);
    timeout_d  = timeout_hit | (timeout_q  & ~clr_err);
    proto_d    = proto_hit   | (proto_q    & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      timer_q    <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      proto_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      proto_q    <= proto_d;
    end
  end

  assign req         = (state_q == REQ);
  assign busy        = (state_q != IDLE) || (cnt_q != '0);
  assign pending_cnt = cnt_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;
  assign proto_err   = proto_q;

endmodule

// File: tb/tb_ack_bus_client.sv
// Scoreboard bench for ack_bus_client: stimulus pushes cycle-stamped expected
// output snapshots, a negedge monitor pops and compares them.
module tb_ack_bus_client;

  localparam logic [1:0] SRC = 2'b00;

  logic       clk = 1'b0;
  logic       rst;
  logic       done_pulse;
  logic       req;
  logic       ack_ready;
  logic [1:0] winner_source_id;
  logic       ack_event;
  logic [2:0] pending_cnt;
  logic       busy;
  logic       overflow;
  logic       timeout_err;
  logic       proto_err;
  logic       clr_err;

  ack_bus_client #(.SRC_ID(SRC), .CNT_W(3), .TO_W(8), .TIMEOUT(200)) dut (
    .clk              (clk),
    .rst              (rst),
    .done_pulse       (done_pulse),
    .req              (req),
    .ack_ready        (ack_ready),
    .winner_source_id (winner_source_id),
    .ack_event        (ack_event),
    .pending_cnt      (pending_cnt),
    .busy             (busy),
    .overflow         (overflow),
    .timeout_err      (timeout_err),
    .proto_err        (proto_err),
    .clr_err          (clr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    string      name;
    logic       req;
    logic [2:0] cnt;
    logic       busy;
    logic       ovf;
    logic       to;
    logic       pe;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Monitor: compare every expectation stamped for the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (e.c < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.c, cyc);
      end else if ({req, pending_cnt, busy, overflow, timeout_err, proto_err} !==
                   {e.req, e.cnt, e.busy, e.ovf, e.to, e.pe}) begin
        errors++;
        $display("FAIL %s @%0d: got req=%b cnt=%0d busy=%b ovf=%b to=%b pe=%b, want req=%b cnt=%0d busy=%b ovf=%b to=%b pe=%b",
                 e.name, cyc, req, pending_cnt, busy, overflow, timeout_err, proto_err,
                 e.req, e.cnt, e.busy, e.ovf, e.to, e.pe);
      end else begin
        $display("check %s @%0d: req=%b cnt=%0d busy=%b ovf=%b to=%b pe=%b ok",
                 e.name, cyc, req, pending_cnt, busy, overflow, timeout_err, proto_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input logic r, input logic [2:0] c,
                            input logic b, input logic ov, input logic t, input logic p);
    exp_t e;
    e.c = cyc; e.name = name; e.req = r; e.cnt = c; e.busy = b;
    e.ovf = ov; e.to = t; e.pe = p;
    exp_q.push_back(e);
  endtask

  task automatic grant(input logic g);
    ack_ready        = g;
    ack_event        = g;
    winner_source_id = SRC;
  endtask

  initial begin
    int req_start;
    rst = 1'b1; done_pulse = 1'b0; ack_ready = 1'b0; ack_event = 1'b0;
    winner_source_id = 2'b00; clr_err = 1'b0;
    tick(); tick();
    rst = 1'b0;
    expect_now("reset", 0, 0, 0, 0, 0, 0);

    // Single ACK: done at T, grant at T+3.
    done_pulse = 1'b1;
    tick(); done_pulse = 1'b0; expect_now("single_T+1", 1, 1, 1, 0, 0, 0);
    tick();                    expect_now("single_T+2", 1, 1, 1, 0, 0, 0);
    tick(); grant(1);          expect_now("single_T+3", 1, 1, 1, 0, 0, 0);
    tick(); grant(0);          expect_now("single_gap", 0, 0, 1, 0, 0, 0);
    tick();                    expect_now("single_idle", 0, 0, 0, 0, 0, 0);

    // ack_ready while IDLE is ignored, even with a bad winner and no event.
    ack_ready = 1'b1; ack_event = 1'b0; winner_source_id = SRC ^ 2'b01;
    tick(); grant(0);          expect_now("idle_ready_ignored", 0, 0, 0, 0, 0, 0);

    // Burst of 3 completions, then drain.
    done_pulse = 1'b1;
    tick();                    expect_now("burst_cnt1", 1, 1, 1, 0, 0, 0);
    tick();                    expect_now("burst_cnt2", 1, 2, 1, 0, 0, 0);
    tick(); done_pulse = 1'b0; expect_now("burst_cnt3", 1, 3, 1, 0, 0, 0);
    for (int i = 2; i >= 0; i--) begin
      grant(1);
      tick(); grant(0);        expect_now("burst_gap", 0, 3'(i), 1, 0, 0, 0);
      tick();
      if (i != 0)              expect_now("burst_rereq", 1, 3'(i), 1, 0, 0, 0);
      else                     expect_now("burst_idle", 0, 0, 0, 0, 0, 0);
    end

    // Completion coincident with accept at cnt=2.
    done_pulse = 1'b1;
    tick();                    expect_now("simul_cnt1", 1, 1, 1, 0, 0, 0);
    tick(); grant(1);          expect_now("simul_cnt2", 1, 2, 1, 0, 0, 0);
    tick(); grant(0); done_pulse = 1'b0;
                               expect_now("simul_gap_hold", 0, 2, 1, 0, 0, 0);
    tick(); grant(1);          expect_now("simul_rereq", 1, 2, 1, 0, 0, 0);
    tick(); grant(0);          expect_now("simul_gap1", 0, 1, 1, 0, 0, 0);
    tick(); grant(1);          expect_now("simul_req1", 1, 1, 1, 0, 0, 0);
    tick(); grant(0);          expect_now("simul_gap0", 0, 0, 1, 0, 0, 0);
    // Completion during GAP with the count at zero returns straight to REQ.
    done_pulse = 1'b1;
    tick(); done_pulse = 1'b0; grant(1);
                               expect_now("gap_done_req", 1, 1, 1, 0, 0, 0);
    tick(); grant(0);          expect_now("gap_done_gap", 0, 0, 1, 0, 0, 0);
    tick();                    expect_now("gap_done_idle", 0, 0, 0, 0, 0, 0);

    // Overflow: 8 completions with no grant.
    req_start = 0;
    for (int i = 0; i < 8; i++) begin
      done_pulse = 1'b1;
      tick();
      if (i == 0) req_start = cyc;
      expect_now("ovf_fill", 1, (i < 7) ? 3'(i + 1) : 3'd7, 1, (i == 7), 0, 0);
    end
    done_pulse = 1'b0;
    clr_err = 1'b1;
    tick(); clr_err = 1'b0;    expect_now("ovf_clr", 1, 7, 1, 0, 0, 0);

    // Timeout: REQ since req_start with no grant.
    while (cyc < req_start + 199) tick();
                               expect_now("timeout_before", 1, 7, 1, 0, 0, 0);
    tick();                    expect_now("timeout_set", 1, 7, 1, 0, 1, 0);

    // Protocol errors.
    ack_ready = 1'b1; ack_event = 1'b1; winner_source_id = SRC ^ 2'b01;
    tick();                    expect_now("proto_wrong_id", 1, 7, 1, 0, 1, 1);
    ack_ready = 1'b1; ack_event = 1'b0; winner_source_id = SRC; clr_err = 1'b1;
    tick(); grant(0);          expect_now("proto_set_beats_clr", 1, 7, 1, 0, 0, 1);
    tick(); clr_err = 1'b0;    expect_now("proto_clr", 1, 7, 1, 0, 0, 0);

    // Drain to 4 pending.
    for (int i = 6; i >= 4; i--) begin
      grant(1);
      tick(); grant(0);        expect_now("drain_gap", 0, 3'(i), 1, 0, 0, 0);
      tick();                  expect_now("drain_req", 1, 3'(i), 1, 0, 0, 0);
    end
    ack_ready = 1'b1; ack_event = 1'b1; winner_source_id = SRC ^ 2'b10;
    tick(); grant(0);          expect_now("pre_rst_proto", 1, 4, 1, 0, 0, 1);

    // Reset mid-request.
    rst = 1'b1; done_pulse = 1'b1;
    tick(); rst = 1'b0; done_pulse = 1'b0;
                               expect_now("rst_mid_req", 0, 0, 0, 0, 0, 0);
    tick();                    expect_now("post_rst_idle", 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) tick();
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never compared, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
